// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths, read
// latency, port indices and the controller state encoding.
package memory_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_RD_LAT = 2;

   localparam logic SOLVER = 1'b0;
   localparam logic INTERP = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      RESP  = ST_RESP
   } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the solver port, interpolation port and shared memory bus.
// The slave modport is the arbiter's view; master is the surrounding system.
interface memory_arbiter_if
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req0, we0, gnt0, done0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0, rdata0;
   logic              req1, we1, gnt1, done1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_rd, mem_wr, busy;

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      output gnt0, done0, rdata0, gnt1, done1, rdata1,
             mem_addr, mem_wdata, mem_rd, mem_wr, busy
   );

   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
      input  gnt0, done0, rdata0, gnt1, done1, rdata1,
             mem_addr, mem_wdata, mem_rd, mem_wr, busy
   );
endinterface

// File: rtl/memory_arbiter_arb_rr2.sv
// Two-way round-robin picker: on contention the port that did not win last
// time is selected; otherwise the single requester wins.
module arb_rr2
   import memory_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic sel,
   output logic any
);
   always_comb begin
      any = req0 | req1;
      sel = SOLVER;
      if (req0 && req1)
         sel = ~last_gnt;
      else if (req1)
         sel = INTERP;
   end
endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one fixed-latency memory between the solver and the
// interpolation ports, one transaction at a time.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input logic             clk,
   input logic             rst,
   memory_arbiter_if.slave bus
);
   arb_state_t        state, state_nx;
   logic [2:0]        cnt;
   logic              last_gnt, cur, lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata, rdata0_q, rdata1_q;
   logic              sel, any;

   arb_rr2 u_pick (
      .req0     (bus.req0),
      .req1     (bus.req1),
      .last_gnt (last_gnt),
      .sel      (sel),
      .any      (any)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any) state_nx = ISSUE;
         ISSUE:   state_nx = lat_we ? RESP : WAIT;
         WAIT:    if (cnt == 3'd1) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Requester inputs are only looked at in IDLE, so a port that drops req or
   // changes addr/wdata mid-transaction cannot disturb the one in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 3'd0;
         last_gnt  <= INTERP;
         cur       <= SOLVER;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  cur       <= sel;
                  lat_we    <= sel ? bus.we1    : bus.we0;
                  lat_addr  <= sel ? bus.addr1  : bus.addr0;
                  lat_wdata <= sel ? bus.wdata1 : bus.wdata0;
               end
            end
            ISSUE: begin
               last_gnt <= cur;
               if (!lat_we)
                  cnt <= 3'(RD_LAT);
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  if (cur == INTERP)
                     rdata1_q <= bus.mem_rdata;
                  else
                     rdata0_q <= bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.gnt0   = 1'b0;
      bus.gnt1   = 1'b0;
      bus.done0  = 1'b0;
      bus.done1  = 1'b0;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      if (state == ISSUE) begin
         bus.gnt0   = (cur == SOLVER);
         bus.gnt1   = (cur == INTERP);
         bus.mem_rd = ~lat_we;
         bus.mem_wr = lat_we;
      end
      if (state == RESP) begin
         bus.done0 = (cur == SOLVER);
         bus.done1 = (cur == INTERP);
      end
   end

   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: three latency builds driven by the same directed
// requests, each checked every cycle against a transaction-timeline model.
module tb_memory_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int            obs_done0 [3];
   int            obs_done1 [3];
   int            obs_rd    [3];
   int            obs_wr    [3];
   logic [DW-1:0] obs_rdata0 [3];
   logic [DW-1:0] obs_rdata1 [3];
   logic [AW-1:0] obs_wr_addr;
   logic [DW-1:0] obs_wr_data;
   int            n_gnt0, n_done0, n_done1;
   int            gnt_order [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int ln, input int c,
                              input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s lane %0d cycle %0d got %0h expected %0h", name, ln, c, act, exp);
      end
   endtask

   // Each lane is one DUT build with its own memory responder and model.
   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

      memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

      assign bus.req0   = req0;
      assign bus.we0    = we0;
      assign bus.addr0  = addr0;
      assign bus.wdata0 = wdata0;
      assign bus.req1   = req1;
      assign bus.we1    = we1;
      assign bus.addr1  = addr1;
      assign bus.wdata1 = wdata1;

      memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      logic [DW-1:0] rmem [256];
      logic [DW-1:0] mmem [256];
      logic [DW-1:0] mrd, rd_dat, rdv, ew;
      logic [DW-1:0] er [2];
      logic [AW-1:0] ea, taddr;
      logic          armed, act, twe, isu, dn;
      int            rd_due, s, p, dc, fr, last, w, c;

      assign bus.mem_rdata = mrd;

      initial begin
         for (int i = 0; i < 256; i++) begin
            rmem[i] = 32'hC0DE0000 | i;
            mmem[i] = 32'hC0DE0000 | i;
         end
         rmem[16] = 32'h00012345;
         mmem[16] = 32'h00012345;
         mrd = '0;
         rd_due = -100;
         armed = 1'b0;
         act = 1'b0;
         s = 0; p = 0; dc = 0; fr = 0; last = 1;
      end

      always @(negedge clk) begin
         c = cyc;
         if (armed) begin
            if (act && !twe && c == dc) er[p] = rdv;
            isu = act && (c == s + 1);
            dn  = act && (c == dc);
            checkOutput("busy",      g, c, 64'(bus.busy),      64'(act && c > s && c <= dc));
            checkOutput("gnt0",      g, c, 64'(bus.gnt0),      64'(isu && p == 0));
            checkOutput("gnt1",      g, c, 64'(bus.gnt1),      64'(isu && p == 1));
            checkOutput("mem_rd",    g, c, 64'(bus.mem_rd),    64'(isu && !twe));
            checkOutput("mem_wr",    g, c, 64'(bus.mem_wr),    64'(isu && twe));
            checkOutput("done0",     g, c, 64'(bus.done0),     64'(dn && p == 0));
            checkOutput("done1",     g, c, 64'(bus.done1),     64'(dn && p == 1));
            checkOutput("mem_addr",  g, c, 64'(bus.mem_addr),  64'(ea));
            checkOutput("mem_wdata", g, c, 64'(bus.mem_wdata), 64'(ew));
            checkOutput("rdata0",    g, c, 64'(bus.rdata0),    64'(er[0]));
            checkOutput("rdata1",    g, c, 64'(bus.rdata1),    64'(er[1]));
         end

         if (bus.done0 === 1'b1) obs_done0[g] = c;
         if (bus.done1 === 1'b1) obs_done1[g] = c;
         if (bus.mem_rd === 1'b1) obs_rd[g] = c;
         if (bus.mem_wr === 1'b1) obs_wr[g] = c;
         obs_rdata0[g] = bus.rdata0;
         obs_rdata1[g] = bus.rdata1;
         if (g == 0) begin
            if (bus.gnt0 === 1'b1) begin n_gnt0++; gnt_order.push_back(0); end
            if (bus.gnt1 === 1'b1) gnt_order.push_back(1);
            if (bus.done0 === 1'b1) n_done0++;
            if (bus.done1 === 1'b1) n_done1++;
            if (bus.mem_wr === 1'b1) begin
               obs_wr_addr = bus.mem_addr;
               obs_wr_data = bus.mem_wdata;
            end
         end

         // Memory: writes land at once, reads answer exactly L cycles after the strobe.
         if (bus.mem_wr === 1'b1) rmem[bus.mem_addr[7:0]] = bus.mem_wdata;
         if (bus.mem_rd === 1'b1) begin
            rd_due = c + L;
            rd_dat = rmem[bus.mem_addr[7:0]];
         end

         if (rst) begin
            armed = 1'b1;
            act   = 1'b0;
            last  = 1;
            er[0] = '0;
            er[1] = '0;
            ea    = '0;
            ew    = '0;
            fr    = c + 1;
         end else if (armed && c >= fr && (req0 || req1)) begin
            w     = (req0 && req1) ? ((last == 0) ? 1 : 0) : (req1 ? 1 : 0);
            act   = 1'b1;
            s     = c;
            p     = w;
            twe   = w ? we1 : we0;
            taddr = w ? addr1 : addr0;
            ew    = w ? wdata1 : wdata0;
            ea    = taddr;
            dc    = twe ? c + 2 : c + 2 + L;
            fr    = dc + 1;
            last  = w;
            if (twe) mmem[taddr[7:0]] = ew;
            else     rdv = mmem[taddr[7:0]];
         end

         mrd = (c == rd_due) ? rd_dat : (32'hA5A50000 ^ c);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic applyStimulus(input logic r,
                                input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      rst = r;
      req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   task automatic clearInputs();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      int t;
      int k;
      int done_exp [3];
      done_exp = '{4, 3, 9};

      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      idle(3);
      clearInputs();
      step();
      checkOutput("rst_busy",      0, cyc, 64'(lane[0].bus.busy),      64'd0);
      checkOutput("rst_rdata1",    0, cyc, 64'(lane[0].bus.rdata1),    64'd0);
      checkOutput("rst_mem_addr",  0, cyc, 64'(lane[0].bus.mem_addr),  64'd0);
      checkOutput("rst_mem_wdata", 0, cyc, 64'(lane[0].bus.mem_wdata), 64'd0);

      $display("[TB] single read on port 1");
      t = cyc;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
      step();
      clearInputs();
      idle(14);
      checkOutput("rd_strobe_dly", 0, cyc, 64'(obs_rd[0] - t), 64'd1);
      for (int g = 0; g < 3; g++) begin
         checkOutput("rd_done_dly", g, cyc, 64'(obs_done1[g] - t), 64'(done_exp[g]));
         checkOutput("rd_data",     g, cyc, 64'(obs_rdata1[g]),    64'h00012345);
      end

      $display("[TB] single write on port 0");
      t = cyc;
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0003, 32'hFFFF8000, 1'b0, 1'b0, '0, '0);
      step();
      clearInputs();
      idle(14);
      checkOutput("wr_strobe_dly", 0, cyc, 64'(obs_wr[0] - t),    64'd1);
      checkOutput("wr_addr",       0, cyc, 64'(obs_wr_addr),      64'h0003);
      checkOutput("wr_data",       0, cyc, 64'(obs_wr_data),      64'hFFFF8000);
      checkOutput("wr_done_dly",   0, cyc, 64'(obs_done0[0] - t), 64'd2);
      for (int g = 0; g < 3; g++)
         checkOutput("wr_rdata0_kept", g, cyc, 64'(obs_rdata0[g]), 64'd0);

      $display("[TB] contention after reset");
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      step();
      n_done0 = 0;
      n_done1 = 0;
      gnt_order.delete();
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0, 16'h0021, '0);
      k = 0;
      while (n_done0 + n_done1 < 3 && k < 100) begin
         step();
         k++;
      end
      clearInputs();
      checkOutput("cont_done_cnt", 0, cyc, 64'(n_done0 + n_done1), 64'd3);
      checkOutput("cont_gnt_cnt",  0, cyc, 64'(gnt_order.size()),  64'd3);
      if (gnt_order.size() >= 3) begin
         checkOutput("cont_order0", 0, cyc, 64'(gnt_order[0]), 64'd0);
         checkOutput("cont_order1", 0, cyc, 64'(gnt_order[1]), 64'd1);
         checkOutput("cont_order2", 0, cyc, 64'(gnt_order[2]), 64'd0);
      end
      idle(14);

      $display("[TB] request dropped during wait");
      n_gnt0 = 0;
      n_done0 = 0;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0030, '0, 1'b0, 1'b0, '0, '0);
      idle(2);
      clearInputs();
      idle(14);
      checkOutput("drop_gnt0_cnt",  0, cyc, 64'(n_gnt0),  64'd1);
      checkOutput("drop_done0_cnt", 0, cyc, 64'(n_done0), 64'd1);
      for (int g = 0; g < 3; g++)
         checkOutput("drop_rdata0", g, cyc, 64'(obs_rdata0[g]), 64'hC0DE0030);

      $display("[TB] reset in first wait cycle");
      n_done1 = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0011, '0);
      step();
      clearInputs();
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      step();
      clearInputs();
      checkOutput("abort_busy",     0, cyc, 64'(lane[0].bus.busy),     64'd0);
      checkOutput("abort_mem_rd",   0, cyc, 64'(lane[0].bus.mem_rd),   64'd0);
      checkOutput("abort_mem_addr", 0, cyc, 64'(lane[0].bus.mem_addr), 64'd0);
      checkOutput("abort_rdata1",   0, cyc, 64'(lane[0].bus.rdata1),   64'd0);
      idle(14);
      checkOutput("abort_no_done", 0, cyc, 64'(n_done1), 64'd0);
      for (int g = 0; g < 3; g++)
         checkOutput("abort_rdata1_kept", g, cyc, 64'(obs_rdata1[g]), 64'd0);

      n_done1 = 0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
      step();
      clearInputs();
      idle(14);
      checkOutput("post_abort_done", 0, cyc, 64'(n_done1), 64'd1);
      for (int g = 0; g < 3; g++)
         checkOutput("post_abort_rdata1", g, cyc, 64'(obs_rdata1[g]), 64'h00012345);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
